// File: rtl/led_scan_ctrl_if.sv
// Framebuffer-side and panel-side signal bundle for led_scan_ctrl.
// The controller uses the master modport; the RAM/plane mux and panel model use slave.
interface led_scan_ctrl_if #(
  parameter int COL_W = 6,
  parameter int ROW_W = 4
);
  logic [ROW_W+COL_W-1:0] mem_addr;
  logic [1:0]             bit_sel;
  logic [5:0]             rgb_in;
  logic [5:0]             panel_rgb;
  logic                   panel_clk;
  logic                   panel_lat;
  logic                   panel_oe_n;
  logic [ROW_W-1:0]       panel_row;
  logic                   frame_start;

  modport master (
    output mem_addr, bit_sel, panel_rgb, panel_clk, panel_lat, panel_oe_n, panel_row, frame_start,
    input  rgb_in
  );

  modport slave (
    input  mem_addr, bit_sel, panel_rgb, panel_clk, panel_lat, panel_oe_n, panel_row, frame_start,
    output rgb_in
  );
endinterface

// File: rtl/led_scan_ctrl.sv
// HUB75 scan controller: shifts bit-planes out of the framebuffer with BCM display timing.
// Optional LED_SCAN_BRIGHT_EN adds a brightness input that shortens the OE-low window.
module led_scan_ctrl #(
  parameter int COL_W    = 6,
  parameter int ROW_W    = 4,
  parameter int BCM_BASE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
`ifdef LED_SCAN_BRIGHT_EN
  input  logic [7:0] brightness,
`endif
  led_scan_ctrl_if.master bus
);

  localparam int COLS     = 1 << COL_W;
  localparam int DISP_MAX = BCM_BASE * 8;
  localparam int CNT_W    = ((COL_W + 2) > ($clog2(DISP_MAX) + 1)) ? (COL_W + 2) : ($clog2(DISP_MAX) + 1);
  localparam logic [CNT_W-1:0] SHIFT_LEN  = CNT_W'(2 * COLS);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(2 * COLS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [1:0]             plane_q, plane_d;
  logic [ROW_W+COL_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]             bit_sel_q, bit_sel_d;
  logic [5:0]             rgb_q, rgb_d;
  logic                   pclk_q, pclk_d;
  logic                   lat_q, lat_d;
  logic                   oe_n_q, oe_n_d;
  logic [ROW_W-1:0]       prow_q, prow_d;
  logic                   fs_q, fs_d;
  logic [CNT_W-1:0]       disp_len;
  logic                   oe_on;
`ifdef LED_SCAN_BRIGHT_EN
  logic [7:0]             bright_q, bright_d;
  logic [CNT_W+7:0]       oe_prod;
`endif

  assign disp_len = CNT_W'(BCM_BASE) << plane_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    row_d   = row_q;
    plane_d = plane_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = S_SHIFT;
          row_d   = '0;
          plane_d = '0;
        end
      end
      S_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end
      end
      S_LATCH: begin
        state_d = S_DISPLAY;
        cnt_d   = '0;
      end
      S_DISPLAY: begin
        if (cnt_q == disp_len - 1'b1) begin
          cnt_d   = '0;
          plane_d = plane_q + 2'd1;
          if (plane_q == 2'd3) row_d = row_q + 1'b1;
          state_d = en ? S_SHIFT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next-cycle state and counter.
  always_comb begin
    mem_addr_d = mem_addr_q;
    if (state_d == S_SHIFT && cnt_d < SHIFT_LEN) mem_addr_d = {row_d, cnt_d[COL_W:1]};
    bit_sel_d = plane_d;
    rgb_d     = rgb_q;
    if (state_q == S_SHIFT && cnt_q[0] && cnt_q < SHIFT_LEN) rgb_d = bus.rgb_in;
    pclk_d = (state_d == S_SHIFT) && cnt_d[0] && (cnt_d >= CNT_W'(3));
    lat_d  = (state_d == S_LATCH);
    prow_d = (state_d == S_LATCH) ? row_q : prow_q;
    fs_d   = (state_d == S_SHIFT) && (cnt_d == '0) && (row_d == '0) && (plane_d == '0);
`ifdef LED_SCAN_BRIGHT_EN
    bright_d = (state_q == S_LATCH) ? brightness : bright_q;
    oe_prod  = {8'b0, disp_len} * {{CNT_W{1'b0}}, bright_d};
    oe_on    = (state_d == S_DISPLAY) && (cnt_d < oe_prod[CNT_W+7:8]);
`else
    oe_on    = (state_d == S_DISPLAY);
`endif
    oe_n_d = ~oe_on;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      mem_addr_q <= '0;
      bit_sel_q  <= '0;
      rgb_q      <= '0;
      pclk_q     <= 1'b0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      prow_q     <= '0;
      fs_q       <= 1'b0;
`ifdef LED_SCAN_BRIGHT_EN
      bright_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      plane_q    <= plane_d;
      mem_addr_q <= mem_addr_d;
      bit_sel_q  <= bit_sel_d;
      rgb_q      <= rgb_d;
      pclk_q     <= pclk_d;
      lat_q      <= lat_d;
      oe_n_q     <= oe_n_d;
      prow_q     <= prow_d;
      fs_q       <= fs_d;
`ifdef LED_SCAN_BRIGHT_EN
      bright_q   <= bright_d;
`endif
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.bit_sel     = bit_sel_q;
  assign bus.panel_rgb   = rgb_q;
  assign bus.panel_clk   = pclk_q;
  assign bus.panel_lat   = lat_q;
  assign bus.panel_oe_n  = oe_n_q;
  assign bus.panel_row   = prow_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: 4x2 panel, BCM_BASE=2, one-cycle framebuffer model.
// Panel events (pixel edges, latches, OE-low widths) are checked against a scoreboard queue.
module tb_led_scan_ctrl;
  localparam int COL_W = 2;
  localparam int ROW_W = 1;
  localparam int BCM   = 2;
  localparam int COLS  = 1 << COL_W;
  localparam int FRAME = 2 * (4 * (2 * COLS + 3) + 15 * BCM);
  localparam int EV_PIX = 1, EV_LAT = 2, EV_OE = 3;
  localparam int BRIGHT = 128;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
`ifdef LED_SCAN_BRIGHT_EN
  logic [7:0] brightness;
`endif

  led_scan_ctrl_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

  led_scan_ctrl #(.COL_W(COL_W), .ROW_W(ROW_W), .BCM_BASE(BCM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
`ifdef LED_SCAN_BRIGHT_EN
    .brightness (brightness),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Framebuffer + plane mux model: data equals the address, one cycle later.
  always @(posedge clk) bus.rgb_in <= 6'(bus.mem_addr);

  typedef struct { int row; int plane; int oe_w; } vec_t;
  typedef struct { int kind; int val; } ev_t;

  vec_t tbl [8];
  ev_t  sb_q [$];
  int   errors = 0;
  int   checks = 0;
  int   oe_cnt = 0;
  logic pclk_prev = 1'b0;
  logic lat_prev  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int outv();
    return int'({bus.mem_addr, bus.bit_sel, bus.panel_rgb, bus.panel_clk, bus.panel_lat,
                 bus.panel_oe_n, bus.panel_row, bus.frame_start});
  endfunction

  function automatic int exp_oe(input int w);
`ifdef LED_SCAN_BRIGHT_EN
    return (w * BRIGHT) >> 8;
`else
    return w;
`endif
  endfunction

  task automatic push_entry(input vec_t v);
    ev_t e;
    for (int c = 0; c < COLS; c++) begin
      e.kind = EV_PIX; e.val = (v.plane << 6) | (v.row * COLS + c); sb_q.push_back(e);
    end
    e.kind = EV_LAT; e.val = v.row; sb_q.push_back(e);
    if (exp_oe(v.oe_w) > 0) begin
      e.kind = EV_OE; e.val = exp_oe(v.oe_w); sb_q.push_back(e);
    end
  endtask

  task automatic sb_event(input int kind, input int val);
    ev_t e;
    string nm;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      nm = (e.kind == EV_PIX) ? "sb_pixel" : (e.kind == EV_LAT) ? "sb_latch_row" : "sb_oe_width";
      check(nm, kind * 1000 + val, e.kind * 1000 + e.val);
    end
  endtask

  // Panel monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      oe_cnt    = 0;
      pclk_prev = 1'b0;
      lat_prev  = 1'b0;
    end else begin
      if (bus.panel_clk && !pclk_prev) begin
        check("oe_high_in_shift", int'(bus.panel_oe_n), 1);
        sb_event(EV_PIX, int'({bus.bit_sel, bus.panel_rgb}));
      end
      if (bus.panel_lat) begin
        check("oe_high_in_latch", int'(bus.panel_oe_n), 1);
        check("latch_one_cycle", int'(lat_prev), 0);
        sb_event(EV_LAT, int'(bus.panel_row));
      end
      if (!bus.panel_oe_n) oe_cnt++;
      else if (oe_cnt > 0) begin
        sb_event(EV_OE, oe_cnt);
        oe_cnt = 0;
      end
      pclk_prev = bus.panel_clk;
      lat_prev  = bus.panel_lat;
    end
  end

  task automatic wait_fs(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < bound);
    check("frame_start_seen", int'(bus.frame_start), 1);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  initial begin
    int n;
    int bad;
    tbl = '{'{0, 0, 2}, '{0, 1, 4}, '{0, 2, 8}, '{0, 3, 16},
            '{1, 0, 2}, '{1, 1, 4}, '{1, 2, 8}, '{1, 3, 16}};
    rst_n = 1'b0;
    en    = 1'b0;
`ifdef LED_SCAN_BRIGHT_EN
    brightness = 8'(BRIGHT);
`endif
    repeat (3) @(negedge clk);
    check("reset_state", outv(), 'h0004);

    // Two full frames: ordering, BCM widths, row wrap and frame period.
    rst_n = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) push_entry(tbl[i]);
    en = 1'b1;
    wait_fs(5, n);   check("fs_latency", n, 1);
    wait_fs(200, n); check("frame_period0", n, FRAME);
    wait_fs(200, n); check("frame_period1", n, FRAME);
    wait_drain(40);

    // Asynchronous reset while OE is low.
    n = 0;
    while (bus.panel_oe_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("oe_low_seen", int'(bus.panel_oe_n), 0);
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outv(), 'h0004);
    @(negedge clk);
    @(negedge clk);
    push_entry(tbl[0]);
    push_entry(tbl[1]);
    rst_n = 1'b1;
    wait_fs(5, n); check("fs_after_reset", n, 1);

    // Drop enable mid-shift of plane 1: plane 1 completes, then idle.
    n = 0;
    while (!(bus.bit_sel == 2'd1 && bus.panel_clk) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("plane1_shift_seen", int'(bus.bit_sel), 1);
    en = 1'b0;
    wait_drain(100);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.panel_clk || bus.panel_lat || !bus.panel_oe_n || bus.frame_start) bad++;
    end
    check("idle_quiet", bad, 0);
    push_entry(tbl[0]);
    push_entry(tbl[1]);
    en = 1'b1;
    wait_fs(5, n); check("fs_reenable", n, 1);
    wait_drain(100);

`ifdef LED_SCAN_BRIGHT_EN
    brightness = 8'd0;
    repeat (80) @(negedge clk);
    bad = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (!bus.panel_oe_n) bad++;
    end
    check("oe_dark_at_zero_brightness", bad, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
